// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined MIPS core. It detects load-use
// hazards, inserts one-cycle bubbles on stall, flush or illegal opcode, and counts stalls.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [31:0]       instr_i,
    input  logic              RegWrite_i,
    input  logic              ALUSrc_i,
    input  logic              RegDst_i,
    input  logic              Branch_i,
    input  logic              MemWrite_i,
    input  logic              MemRead_i,
    input  logic              MemtoReg_i,
    input  logic [7:0]        ALU_op_i,
    input  logic [31:0]       rs_data_i,
    input  logic [31:0]       rt_data_i,
    input  logic [31:0]       imm_i,
    input  logic [31:0]       pc4_i,
    output logic              RegWrite_o,
    output logic              ALUSrc_o,
    output logic              RegDst_o,
    output logic              Branch_o,
    output logic              MemWrite_o,
    output logic              MemRead_o,
    output logic              MemtoReg_o,
    output logic [7:0]        ALU_op_o,
    output logic [31:0]       rs_data_o,
    output logic [31:0]       rt_data_o,
    output logic [31:0]       imm_o,
    output logic [31:0]       pc4_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic              valid_o,
    output logic              stall_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       op_legal, rt_is_src;

    assign op = instr_i[31:26];
    assign rs = instr_i[25:21];
    assign rt = instr_i[20:16];
    assign rd = instr_i[15:11];

    always_comb begin
        op_legal  = 1'b0;
        rt_is_src = 1'b0;
        case (op)
            OP_R, OP_SW, OP_BEQ: begin
                op_legal  = 1'b1;
                rt_is_src = 1'b1;
            end
            OP_ADDI, OP_LW, OP_SLTI: op_legal = 1'b1;
            default: ;
        endcase
    end

    // Control word packed as {RegWrite, ALUSrc, RegDst, Branch, MemWrite, MemRead, MemtoReg}
    logic [6:0]       ctrl_q, ctrl_d;
    logic [7:0]       alu_op_q, alu_op_d;
    logic [31:0]      rs_data_q, rs_data_d, rt_data_q, rt_data_d;
    logic [31:0]      imm_q, imm_d, pc4_q, pc4_d;
    logic [4:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic             valid_q, valid_d, illegal_q, illegal_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // $0 is never a real producer; flush overrides the hazard.
    assign stall_o = ~flush_i & ctrl_q[1] & valid_q & (rt_q != 5'd0)
                   & ((rt_q == rs) | ((rt_q == rt) & rt_is_src));

    always_comb begin
        ctrl_d      = '0;
        alu_op_d    = '0;
        rs_data_d   = '0;
        rt_data_d   = '0;
        imm_d       = '0;
        pc4_d       = '0;
        rs_d        = '0;
        rt_d        = '0;
        rd_d        = '0;
        valid_d     = 1'b0;
        illegal_d   = 1'b0;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
        end else if (stall_o) begin
            if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else if (!op_legal) begin
            illegal_d = 1'b1;
        end else begin
            ctrl_d    = {RegWrite_i, ALUSrc_i, RegDst_i, Branch_i,
                         MemWrite_i, MemRead_i, MemtoReg_i};
            alu_op_d  = ALU_op_i;
            rs_data_d = rs_data_i;
            rt_data_d = rt_data_i;
            imm_d     = imm_i;
            pc4_d     = pc4_i;
            rs_d      = rs;
            rt_d      = rt;
            rd_d      = rd;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q      <= '0;
            alu_op_q    <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            alu_op_q    <= alu_op_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            pc4_q       <= pc4_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            valid_q     <= valid_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign {RegWrite_o, ALUSrc_o, RegDst_o, Branch_o,
            MemWrite_o, MemRead_o, MemtoReg_o} = ctrl_q;
    assign ALU_op_o    = alu_op_q;
    assign rs_data_o   = rs_data_q;
    assign rt_data_o   = rt_data_q;
    assign imm_o       = imm_q;
    assign pc4_o       = pc4_q;
    assign rs_o        = rs_q;
    assign rt_o        = rt_q;
    assign rd_o        = rd_q;
    assign valid_o     = valid_q;
    assign illegal_o   = illegal_q;
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver pushes hand-computed expectations,
// a monitor pops and compares them against the DUT every cycle.
module tb_id_ex_stage;
    logic        clk_i = 1'b0;
    logic        rst_i, flush_i;
    logic [31:0] instr_i, rs_data_i, rt_data_i, imm_i, pc4_i;
    logic        RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, MemWrite_i, MemRead_i, MemtoReg_i;
    logic [7:0]  ALU_op_i;

    logic        RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, MemWrite_o, MemRead_o, MemtoReg_o;
    logic [7:0]  ALU_op_o;
    logic [31:0] rs_data_o, rt_data_o, imm_o, pc4_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic        valid_o, stall_o, illegal_o;
    logic [15:0] stall_cnt_o;

    logic        s_RegWrite, s_ALUSrc, s_RegDst, s_Branch, s_MemWrite, s_MemRead, s_MemtoReg;
    logic [7:0]  s_ALU_op;
    logic [31:0] s_rs_data, s_rt_data, s_imm, s_pc4;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic        s_valid, s_stall, s_illegal;
    logic [1:0]  s_cnt;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .instr_i(instr_i),
        .RegWrite_i(RegWrite_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .Branch_i(Branch_i),
        .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .MemtoReg_i(MemtoReg_i),
        .ALU_op_i(ALU_op_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .pc4_i(pc4_i),
        .RegWrite_o(RegWrite_o), .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o), .Branch_o(Branch_o),
        .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o), .MemtoReg_o(MemtoReg_o),
        .ALU_op_o(ALU_op_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
        .pc4_o(pc4_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .valid_o(valid_o),
        .stall_o(stall_o), .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
    );

    // Narrow-counter instance sharing the same stimulus, used to reach saturation quickly.
    id_ex_stage #(.CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .instr_i(instr_i),
        .RegWrite_i(RegWrite_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .Branch_i(Branch_i),
        .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .MemtoReg_i(MemtoReg_i),
        .ALU_op_i(ALU_op_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .pc4_i(pc4_i),
        .RegWrite_o(s_RegWrite), .ALUSrc_o(s_ALUSrc), .RegDst_o(s_RegDst), .Branch_o(s_Branch),
        .MemWrite_o(s_MemWrite), .MemRead_o(s_MemRead), .MemtoReg_o(s_MemtoReg),
        .ALU_op_o(s_ALU_op), .rs_data_o(s_rs_data), .rt_data_o(s_rt_data), .imm_o(s_imm),
        .pc4_o(s_pc4), .rs_o(s_rs), .rt_o(s_rt), .rd_o(s_rd), .valid_o(s_valid),
        .stall_o(s_stall), .illegal_o(s_illegal), .stall_cnt_o(s_cnt)
    );

    typedef struct {
        logic        rst, flush;
        logic [31:0] instr;
        logic [6:0]  ctrl;
        logic [7:0]  alu;
        logic [31:0] rsd, rtd, imm, pc4;
    } in_t;

    typedef struct {
        logic        chk_stall, stall, valid, illegal;
        logic [6:0]  ctrl;
        logic [7:0]  alu;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm, pc4;
        logic [15:0] cnt;
        logic [1:0]  cnt_s;
        int          id;
    } exp_t;

    localparam logic [6:0] CT_LW   = 7'b1100011;
    localparam logic [6:0] CT_R    = 7'b1010000;
    localparam logic [6:0] CT_ADDI = 7'b1100000;
    localparam logic [6:0] CT_SW   = 7'b0100100;
    localparam logic [6:0] CT_BAD  = 7'b1111111;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    function automatic in_t mk(logic rst, logic flush, logic [5:0] op, logic [4:0] rs,
                               logic [4:0] rt, logic [15:0] low, logic [6:0] ctrl,
                               logic [31:0] rsd, logic [31:0] rtd, logic [31:0] pc4);
        in_t t;
        t.rst = rst; t.flush = flush;
        t.instr = {op, rs, rt, low};
        t.ctrl = ctrl; t.alu = {2'b00, op};
        t.rsd = rsd; t.rtd = rtd;
        t.imm = {{16{low[15]}}, low};
        t.pc4 = pc4;
        return t;
    endfunction

    task automatic issue(input in_t t, input logic chk_stall, input logic stall,
                         input logic load, input logic illegal,
                         input logic [15:0] cnt, input logic [1:0] cnt_s);
        exp_t e;
        @(posedge clk_i);
        #2;
        rst_i = t.rst; flush_i = t.flush; instr_i = t.instr;
        {RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, MemWrite_i, MemRead_i, MemtoReg_i} = t.ctrl;
        ALU_op_i = t.alu; rs_data_i = t.rsd; rt_data_i = t.rtd; imm_i = t.imm; pc4_i = t.pc4;
        e.chk_stall = chk_stall; e.stall = stall; e.valid = load; e.illegal = illegal;
        e.ctrl = load ? t.ctrl : 7'd0;
        e.alu  = load ? t.alu : 8'd0;
        e.rs   = load ? t.instr[25:21] : 5'd0;
        e.rt   = load ? t.instr[20:16] : 5'd0;
        e.rd   = load ? t.instr[15:11] : 5'd0;
        e.rsd  = load ? t.rsd : 32'd0;
        e.rtd  = load ? t.rtd : 32'd0;
        e.imm  = load ? t.imm : 32'd0;
        e.pc4  = load ? t.pc4 : 32'd0;
        e.cnt = cnt; e.cnt_s = cnt_s; e.id = txn;
        txn++;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int id, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL txn %0d %s: got %0h required %0h", id, name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0) begin
                e = sb[0];
                if (e.chk_stall) chk("stall", e.id, 128'(stall_o), 128'(e.stall));
                @(posedge clk_i);
                #1;
                e = sb.pop_front();
                chk("ctrl", e.id,
                    128'({valid_o, illegal_o, RegWrite_o, ALUSrc_o, RegDst_o, Branch_o,
                          MemWrite_o, MemRead_o, MemtoReg_o, ALU_op_o}),
                    128'({e.valid, e.illegal, e.ctrl, e.alu}));
                chk("addr", e.id, 128'({rs_o, rt_o, rd_o}), 128'({e.rs, e.rt, e.rd}));
                chk("data", e.id, {rs_data_o, rt_data_o, imm_o, pc4_o},
                    {e.rsd, e.rtd, e.imm, e.pc4});
                chk("cnt", e.id, 128'(stall_cnt_o), 128'(e.cnt));
                chk("cnt_sat", e.id, 128'(s_cnt), 128'(e.cnt_s));
                $display("txn %0d: stall=%0b valid=%0b illegal=%0b alu=%0h cnt=%0d sat=%0d",
                         e.id, stall_o, valid_o, illegal_o, ALU_op_o, stall_cnt_o, s_cnt);
            end
        end
    end

    initial begin : driver
        in_t lw9, add_dep, sw_dep, lwl;
        rst_i = 1'b1; flush_i = 1'b0; instr_i = '0;
        {RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, MemWrite_i, MemRead_i, MemtoReg_i} = '0;
        ALU_op_i = '0; rs_data_i = '0; rt_data_i = '0; imm_i = '0; pc4_i = '0;

        // Reset with arbitrary inputs
        issue(mk(1, 0, 6'h23, 5'd5, 5'd6, 16'h1234, CT_LW, 32'hDEAD, 32'hBEEF, 32'h40),
              0, 0, 0, 0, 16'd0, 2'd0);
        issue(mk(1, 0, 6'h00, 5'd6, 5'd5, 16'h3800, CT_R, 32'h1, 32'h2, 32'h44),
              1, 0, 0, 0, 16'd0, 2'd0);
        // ADDI $t1,$t0,5
        issue(mk(0, 0, 6'h08, 5'd8, 5'd9, 16'd5, CT_ADDI, 32'd7, 32'h11, 32'h104),
              1, 0, 1, 0, 16'd0, 2'd0);
        // LW $t1 then dependent ADD $t2,$t1,$t3
        lw9 = mk(0, 0, 6'h23, 5'd8, 5'd9, 16'd0, CT_LW, 32'h100, 32'h0, 32'h108);
        issue(lw9, 1, 0, 1, 0, 16'd0, 2'd0);
        add_dep = mk(0, 0, 6'h00, 5'd9, 5'd11, {5'd10, 11'h020}, CT_R, 32'h55, 32'h66, 32'h10C);
        issue(add_dep, 1, 1, 0, 0, 16'd1, 2'd1);
        issue(add_dep, 1, 0, 1, 0, 16'd1, 2'd1);
        // LW $0 then ADD using $0: no hazard
        issue(mk(0, 0, 6'h23, 5'd8, 5'd0, 16'd4, CT_LW, 32'h100, 32'h0, 32'h110),
              1, 0, 1, 0, 16'd1, 2'd1);
        issue(mk(0, 0, 6'h00, 5'd0, 5'd0, {5'd10, 11'h020}, CT_R, 32'h0, 32'h0, 32'h114),
              1, 0, 1, 0, 16'd1, 2'd1);
        // LW $t1 then ADDI $t1,$t2,1: rt not a source
        issue(lw9, 1, 0, 1, 0, 16'd1, 2'd1);
        issue(mk(0, 0, 6'h08, 5'd10, 5'd9, 16'd1, CT_ADDI, 32'h3, 32'h4, 32'h118),
              1, 0, 1, 0, 16'd1, 2'd1);
        // Hazard together with flush: flush wins
        issue(lw9, 1, 0, 1, 0, 16'd1, 2'd1);
        issue(mk(0, 1, 6'h00, 5'd12, 5'd9, {5'd13, 11'h020}, CT_R, 32'h7, 32'h8, 32'h120),
              1, 0, 0, 0, 16'd1, 2'd1);
        // Illegal opcode 0x3F with garbage control, then illegal_o must drop
        issue(mk(0, 0, 6'h3F, 5'd9, 5'd9, 16'hFFFF, CT_BAD, 32'hA, 32'hB, 32'h124),
              1, 0, 0, 1, 16'd1, 2'd1);
        issue(mk(0, 0, 6'h2B, 5'd8, 5'd9, 16'd8, CT_SW, 32'h200, 32'h77, 32'h128),
              1, 0, 1, 0, 16'd1, 2'd1);
        // LW $t1 then SW $t1: rt is a source for stores
        issue(lw9, 1, 0, 1, 0, 16'd1, 2'd1);
        sw_dep = mk(0, 0, 6'h2B, 5'd8, 5'd9, 16'd12, CT_SW, 32'h200, 32'h88, 32'h130);
        issue(sw_dep, 1, 1, 0, 0, 16'd2, 2'd2);
        issue(sw_dep, 1, 0, 1, 0, 16'd2, 2'd2);
        // Back-to-back dependent loads; the 2-bit counter saturates at 3
        lwl = mk(0, 0, 6'h23, 5'd9, 5'd9, 16'd0, CT_LW, 32'h300, 32'h0, 32'h134);
        issue(lwl, 1, 0, 1, 0, 16'd2, 2'd2);
        for (int i = 0; i < 4; i++) begin
            issue(lwl, 1, 1, 0, 0, 16'(3 + i), 2'd3);
            issue(lwl, 1, 0, 1, 0, 16'(3 + i), 2'd3);
        end
        // Reset asserted while a stall is pending
        lwl.rst = 1'b1;
        issue(lwl, 1, 1, 0, 0, 16'd0, 2'd0);
        lwl.rst = 1'b0;
        issue(lwl, 1, 0, 1, 0, 16'd0, 2'd0);
        issue(mk(0, 0, 6'h0A, 5'd4, 5'd5, 16'hFFF0, CT_ADDI, 32'h9, 32'hA, 32'h138),
              1, 0, 1, 0, 16'd0, 2'd0);

        repeat (3) @(posedge clk_i);
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
